lut_key_finder: RTL and testbench

//  Reverse direction of the branch-target lookup table: takes an 8-bit target address and returns the
//  5-bit key whose table entry holds that address. Holds its own writable copy of the table.

---
 rtl/lut_key_finder_pkg.sv | 24 ++
 rtl/lut_key_finder_table.sv | 41 ++++
 rtl/lut_key_finder.sv | 97 +++++++++
 tb/tb_lut_key_finder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_key_finder_pkg.sv
// Shared parameters, types and the power-on contents of the branch-target table
// for the reverse (address -> key) lookup.
package lut_pkg;

    localparam int KEY_W     = 5;
    localparam int ADDR_W    = 8;
    localparam int N_ENTRIES = 18;

    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Single source for the table contents restored on every reset.
    localparam addr_t LUT_DEFAULT [N_ENTRIES] = '{
        8'd32,  8'd33,  8'd34,  8'd35,  8'd60,  8'd64,  8'd91,  8'd109, 8'd128,
        8'd142, 8'd168, 8'd170, 8'd200, 8'd204, 8'd224, 8'd232, 8'd240, 8'd254
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lkf_state_t;

endpackage

// File: rtl/lut_key_finder_table.sv
// Writable copy of the branch-target table: per-entry registers that reload
// their defaults on reset, one range-checked write port and one read port.
module lut_key_table
    import lut_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset_n,
    input  logic  wr_en,
    input  key_t  wr_key,
    input  addr_t wr_addr,
    input  key_t  rd_idx,
    output addr_t rd_addr
);

    addr_t r_table [N_ENTRIES];
    logic  w_wr_ok;

    assign w_wr_ok = wr_en && (wr_key < KEY_W'(N_ENTRIES));

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
        // One entry: reload default on reset, take the write when addressed.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_table[g] <= LUT_DEFAULT[g];
            end else if (w_wr_ok && (wr_key == KEY_W'(g))) begin
                r_table[g] <= wr_addr;
            end
        end
    end

    // Read port; an out-of-range index returns zero rather than an undefined entry.
    always_comb begin
        rd_addr = '0;
        if (rd_idx < KEY_W'(N_ENTRIES)) begin
            rd_addr = r_table[rd_idx];
        end else begin
            rd_addr = '0;
        end
    end

endmodule

// File: rtl/lut_key_finder.sv
// Resolves an 8-bit branch target back to its 5-bit key by scanning the table
// upward one entry per cycle; valid/ready handshake on request and response.
module lut_key_finder
    import lut_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset_n,
    input  logic  req_valid,
    output logic  req_ready,
    input  addr_t req_addr,
    input  logic  wr_en,
    input  key_t  wr_key,
    input  addr_t wr_addr,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output key_t  rsp_key,
    output logic  rsp_hit
);

    lkf_state_t r_state;
    key_t       r_idx;
    addr_t      r_addr;
    logic       r_req_ready;
    logic       r_rsp_valid;
    key_t       r_rsp_key;
    logic       r_rsp_hit;
    addr_t      w_entry;

    lut_key_table u_table (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (wr_en),
        .wr_key  (wr_key),
        .wr_addr (wr_addr),
        .rd_idx  (r_idx),
        .rd_addr (w_entry)
    );

    // Lookup FSM with the scan counter, latched address and response registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_key   <= '0;
            r_rsp_hit   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_entry == r_addr) begin
                        r_rsp_key <= r_idx;
                        r_rsp_hit <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_idx == KEY_W'(N_ENTRIES - 1)) begin
                        r_rsp_key <= '0;
                        r_rsp_hit <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx + KEY_W'(1);
                    end
                end
                DONE: begin
                    // rsp_valid rises one cycle after entering DONE, then holds until taken.
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_key   = r_rsp_key;
    assign rsp_hit   = r_rsp_hit;

endmodule

// File: tb/tb_lut_key_finder.sv
// Directed self-checking bench for lut_key_finder: latency, hit/miss, table
// writes, response back-pressure and reset during a scan.
module tb_lut_key_finder;

    logic       Clk;
    logic       Reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic       wr_en;
    logic [4:0] wr_key;
    logic [7:0] wr_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_key;
    logic       rsp_hit;

    int n_cmp;
    int n_bad;

    lut_key_finder dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .wr_en     (wr_en),
        .wr_key    (wr_key),
        .wr_addr   (wr_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_key   (rsp_key),
        .rsp_hit   (rsp_hit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [4:0] key, input logic hit);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_key"}, 32'(rsp_key), 32'(key));
        chk({tag, "_rsp_hit"}, 32'(rsp_hit), 32'(hit));
    endtask

    // Called at posedge+1; drives one write that is captured at the next edge.
    task automatic do_write(input logic [4:0] key, input logic [7:0] addr);
        wr_en   = 1'b1;
        wr_key  = key;
        wr_addr = addr;
        @(posedge Clk);
        #1;
        wr_en   = 1'b0;
        wr_key  = 5'd0;
        wr_addr = 8'd0;
    endtask

    // Called at posedge+1 with req_ready high; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [7:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ~addr;
    endtask

    // Counts edges after the accept edge until rsp_valid, checks result, then takes it.
    task automatic wait_rsp(input string tag, input logic [4:0] key, input logic hit, input int lat);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_key"}, 32'(rsp_key), 32'(key));
        chk({tag, "_hit"}, 32'(rsp_hit), 32'(hit));
        chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge Clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic lookup(input string tag, input logic [7:0] addr, input logic [4:0] key,
                          input logic hit, input int lat);
        issue(addr);
        wait_rsp(tag, key, hit, lat);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        Reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 8'd0;
        wr_en     = 1'b0;
        wr_key    = 5'd0;
        wr_addr   = 8'd0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        chk_idle_outputs("reset", 5'd0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // 1-2: hit, miss, last entry
        lookup("t1_addr60", 8'd60, 5'd4, 1'b1, 6);
        lookup("t2_addr61", 8'd61, 5'd0, 1'b0, 19);
        lookup("t2_addr254", 8'd254, 5'd17, 1'b1, 19);
        lookup("t2_addr32", 8'd32, 5'd0, 1'b1, 2);

        // 3: duplicates resolve to the lowest key
        do_write(5'd17, 8'd32);
        lookup("t3_dup_low", 8'd32, 5'd0, 1'b1, 2);
        do_write(5'd0, 8'd99);
        lookup("t3_dup_17", 8'd32, 5'd17, 1'b1, 19);
        lookup("t3_new99", 8'd99, 5'd0, 1'b1, 2);

        // 4: back-pressure in DONE with a pending request
        issue(8'd60);
        wait_rsp_hold();

        // 5: out-of-range write ignored
        do_write(5'd20, 8'd5);
        lookup("t5_addr5", 8'd5, 5'd0, 1'b0, 19);
        lookup("t5_addr35", 8'd35, 5'd3, 1'b1, 5);

        // 6: reset mid-scan drops the transaction and restores the table
        do_write(5'd2, 8'd77);
        issue(8'd150);
        repeat (7) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk_idle_outputs("t6_reset", 5'd0, 1'b0);
        @(posedge Clk);
        #1;
        chk_idle_outputs("t6_reset_hold", 5'd0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        lookup("t6_addr34", 8'd34, 5'd2, 1'b1, 4);
        lookup("t6_addr77", 8'd77, 5'd0, 1'b0, 19);
        lookup("t6_addr32", 8'd32, 5'd0, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Response for addr 60 held for 4 cycles while a request for 91 waits.
    task automatic wait_rsp_hold();
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("t4_latency", 32'(n), 32'd6);
        req_valid = 1'b1;
        req_addr  = 8'd91;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_key", 32'(rsp_key), 32'd4);
            chk("t4_hold_hit", 32'(rsp_hit), 32'd1);
            chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge Clk);
        #1;
        rsp_ready = 1'b0;
        chk("t4_hs_valid_drop", 32'(rsp_valid), 32'd0);
        chk("t4_hs_not_accepted", 32'(req_ready), 32'd1);
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 8'd0;
        chk("t4_pending_accepted", 32'(req_ready), 32'd0);
        wait_rsp("t4_addr91", 5'd6, 1'b1, 8);
    endtask

endmodule
